// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end:
// the key event record, decoder states, prefix bytes and the discard list.
package ps2_pkg;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_evt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_OVR0   = 8'h00;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_OVR1   = 8'hFF;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == PS2_OVR0) || (b == PS2_BAT_OK) || (b == PS2_PAUSE) ||
           (b == PS2_ACK)  || (b == PS2_RESEND) || (b == PS2_OVR1);
  endfunction

  // Legacy packed key word: optional E0 and F0 prefix bytes ahead of the code.
  function automatic logic [31:0] pack_key(input key_evt_t e);
    logic [31:0] k;
    k = {24'h000000, e.code};
    if (e.ext && e.brk)  k = {8'h00, PS2_EXT, PS2_BRK, e.code};
    else if (e.ext)      k = {16'h0000, PS2_EXT, e.code};
    else if (e.brk)      k = {16'h0000, PS2_BRK, e.code};
    return k;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Event handshake between the key decoder (master) and the CPU-side consumer (slave).
interface ps2_key_decoder_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;

  modport master (output evt_valid, evt_code, evt_ext, evt_brk, input evt_ready);
  modport slave  (input evt_valid, evt_code, evt_ext, evt_brk, output evt_ready);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: line synchroniser, falling-edge detect, shifter,
// odd-parity/stop check and an inter-edge timeout that abandons partial frames.
module ps2_frame_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       en,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic          clk_q;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo;
  logic          fall, din;

  assign fall = clk_q & ~clk_sync[SYNC_STAGES-1];
  assign din  = dat_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!clrn || !en) begin
      // Idle PS/2 lines are high; preload so leaving reset never fakes an edge.
      clk_sync   <= '1;
      dat_sync   <= '1;
      clk_q      <= 1'b1;
      bit_cnt    <= 4'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      tmo        <= '0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      byte_err   <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync   <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_q      <= clk_sync[SYNC_STAGES-1];
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      if (fall) begin
        tmo <= TW'(TIMEOUT_CYCLES - 1);
        if (bit_cnt == 4'd0) begin
          if (!din) bit_cnt <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          shreg   <= {din, shreg[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          par_bit <= din;
          bit_cnt <= 4'd10;
        end else begin
          bit_cnt <= 4'd0;
          if (din && (^{shreg, par_bit})) begin
            byte_valid <= 1'b1;
            byte_data  <= shreg;
          end else begin
            byte_err <= 1'b1;
          end
        end
      end else if (bit_cnt != 4'd0) begin
        if (tmo == '0) bit_cnt <= 4'd0;
        else           tmo     <= tmo - 1'b1;
      end
    end
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: E0/F0 prefix decoder, event FIFO, legacy cur_key and sticky errors.
// Optional typematic-repeat filter enabled by defining KBD_REPEAT_FILTER_EN.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                        clk,
  input  logic                        clrn,
  input  logic                        en,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  input  logic                        clr_err,
  ps2_key_decoder_if.master           evt,
  output logic [31:0]                 cur_key,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        frame_err
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic       byte_valid, byte_err;
  logic [7:0] byte_data;

  ps2_frame_rx #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk(clk), .clrn(clrn), .en(en), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_err(byte_err)
  );

  dec_state_t state, state_nxt;
  logic       emit;
  key_evt_t   emit_evt;

  always_ff @(posedge clk) begin
    if (!clrn || !en) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    emit          = 1'b0;
    emit_evt.code = byte_data;
    emit_evt.ext  = 1'b0;
    emit_evt.brk  = 1'b0;
    if (byte_err) begin
      state_nxt = ST_IDLE;
    end else if (byte_valid) begin
      case (state)
        ST_IDLE: begin
          if (byte_data == PS2_EXT)      state_nxt = ST_EXT;
          else if (byte_data == PS2_BRK) state_nxt = ST_BRK;
          else if (!is_discard(byte_data)) emit = 1'b1;
        end
        ST_EXT: begin
          if (byte_data == PS2_BRK) begin
            state_nxt = ST_EXT_BRK;
          end else begin
            emit         = 1'b1;
            emit_evt.ext = 1'b1;
            state_nxt    = ST_IDLE;
          end
        end
        ST_BRK: begin
          emit         = 1'b1;
          emit_evt.brk = 1'b1;
          state_nxt    = ST_IDLE;
        end
        default: begin
          emit         = 1'b1;
          emit_evt.ext = 1'b1;
          emit_evt.brk = 1'b1;
          state_nxt    = ST_IDLE;
        end
      endcase
    end
  end

  logic suppress;
`ifdef KBD_REPEAT_FILTER_EN
  logic       rpt_valid;
  logic [8:0] rpt_key;
  logic       rpt_hit;

  assign rpt_hit  = rpt_valid && (rpt_key == {emit_evt.ext, emit_evt.code});
  assign suppress = emit && !emit_evt.brk && rpt_hit;

  always_ff @(posedge clk) begin
    if (!clrn || !en) begin
      rpt_valid <= 1'b0;
      rpt_key   <= 9'h000;
    end else if (emit && !suppress) begin
      if (!emit_evt.brk) begin
        rpt_valid <= 1'b1;
        rpt_key   <= {emit_evt.ext, emit_evt.code};
      end else if (rpt_hit) begin
        rpt_valid <= 1'b0;
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  key_evt_t      mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, do_push, push_ok;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = evt.evt_valid && evt.evt_ready;
  assign do_push = emit && !suppress;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok = do_push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= emit_evt;
  end

  always_ff @(posedge clk) begin
    if (!clrn || !en) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      cur_key <= 32'h0;
    end else begin
      if (push_ok) begin
        wr_ptr  <= wr_ptr + 1'b1;
        cur_key <= pack_key(emit_evt);
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else if (en) begin
      overflow  <= (overflow && !clr_err) || (do_push && !push_ok);
      frame_err <= (frame_err && !clr_err) || byte_err;
    end
  end

  assign evt.evt_valid = (count != '0);
  assign evt.evt_code  = evt.evt_valid ? mem[rd_ptr].code : 8'h00;
  assign evt.evt_ext   = evt.evt_valid ? mem[rd_ptr].ext  : 1'b0;
  assign evt.evt_brk   = evt.evt_valid ? mem[rd_ptr].brk  : 1'b0;
  assign fifo_count    = count;
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised PS/2 keyboard front end. It receives raw PS/2 frames and decodes the E0/F0 prefix sequences into single key events. Decoded events are buffered in a FIFO and handed to the CPU-side consumer with a valid/ready handshake. It replaces the single-register keyboard latch: it adds frame checking, an event queue, error flags and optional typematic-repeat filtering, and still provides the legacy packed `cur_key` word.

## Interface
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, 2: flip-flop stages on `ps2_clk`/`ps2_data`, ≥2.
- `TIMEOUT_CYCLES`, 100000: number of `clk` cycles without a PS/2 falling edge before a partial frame is abandoned.
- `clk` in 1: system clock. The block has one clock; all logic is on its rising edge.
- `clrn` in 1: reset. Synchronous and active-low.
- `en` in 1: block enable. Low flushes the block (see Operation).
- `ps2_clk` in 1: raw PS/2 clock, asynchronous.
- `ps2_data` in 1: raw PS/2 data, asynchronous.
- `evt_valid` out 1: FIFO not empty.
- `evt_ready` in 1: consumer accepts the head entry.
- `evt_code` out 8: scan code of the head entry.
- `evt_ext` out 1: head entry had an E0 prefix.
- `evt_brk` out 1: head entry is a release.
- `cur_key` out 32: packed form of the last accepted event.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of occupied entries.
- `overflow` out 1: sticky; an event was dropped because the FIFO was full.
- `frame_err` out 1: sticky; a frame had a parity or stop-bit error.
- `clr_err` in 1: clears `overflow` and `frame_err`.

## Operation
- **Reset** (`clrn`=0 at a clock edge):
  - all outputs 0; FIFO empty;
  - receiver idle, bit counter 0;
  - decoder in IDLE;
  - repeat register invalid.
- **Enable low:** `en`=0 has the same effect as reset, except that the sticky flags hold their values.
- **Receiver:**
  - synchronises both PS/2 lines, then samples `ps2_data` on each synchronised falling edge of `ps2_clk`;
  - frame format: start bit 0, 8 data bits LSB first, odd parity, stop bit 1;
  - start bit = 1: the edge is ignored and the receiver stays idle;
  - bad parity or stop bit = 0: the byte is dropped, `frame_err` is set, and the decoder is forced to IDLE;
  - no edge for `TIMEOUT_CYCLES`: the bit counter returns to 0 and the partial frame is lost silently.
- **Decoder FSM** (IDLE, EXT, BRK, EXT_BRK):
  - IDLE: E0 → EXT; F0 → BRK; bytes 00, AA, E1, FA, FE, FF are discarded; any other byte emits {code, ext=0, brk=0}.
  - EXT: F0 → EXT_BRK; any other byte emits {code, ext=1, brk=0} → IDLE.
  - BRK: any byte emits {code, ext=0, brk=1} → IDLE.
  - EXT_BRK: any byte emits {code, ext=1, brk=1} → IDLE.
- **FIFO:**
  - first-word fall-through: the `evt_*` outputs show the head entry whenever `evt_valid`=1;
  - pop when `evt_valid && evt_ready`;
  - emit while full: the event is dropped and `overflow` is set;
  - emit and pop in the same cycle while full: the push is accepted and the count is unchanged;
  - emit and pop in the same cycle while empty: no bypass; the new entry becomes visible next cycle.
- **`cur_key`:** updated on every accepted push.
  - make: {24'h000000, code}
  - ext make: {16'h0000, 8'hE0, code}
  - break: {16'h0000, 8'hF0, code}
  - ext break: {8'h00, 8'hE0, 8'hF0, code}
- **Sticky flags:** `clr_err` and a new set event in the same cycle leave the flag set.

## Timing
- Let T be the cycle in which the synchronised stop-bit falling edge is detected.
- T+1: the byte is registered, the FSM updates, and the emitted event is written to the FIFO.
- T+2: `evt_valid`, `fifo_count` and `cur_key` reflect the event.
- Pin-to-`evt_valid` latency is SYNC_STAGES+2 cycles after the edge reaches the pin.
- A pop takes effect at the next edge; the next head entry is visible the cycle after the handshake.
- Back-to-back pops at one per cycle are supported.

## Configuration
- `KBD_REPEAT_FILTER_EN` defined:
  - a make event equal to the last accepted make {ext, code} is suppressed until a break with the same {ext, code} is seen;
  - that break invalidates the register;
  - suppressed events change neither the FIFO nor `cur_key`.
- Not defined: every typematic make is queued.

## Structure
- Package `ps2_pkg` holds:
  - the `key_evt_t` struct {code, ext, brk};
  - the FSM state enum;
  - the constants `PS2_EXT`=8'hE0 and `PS2_BRK`=8'hF0;
  - the discard-list constants.
- Sub-module `ps2_frame_rx` contains the synchroniser, edge detector, shifter, parity check and timeout, and outputs `byte_valid`, `byte_data` and `byte_err`.
- The FSM, repeat filter, FIFO and `cur_key` logic stay in the top module.

## Test plan
- Send 1C, F0 1C with `evt_ready`=1 → events {1C,0,0} then {1C,0,1}; `cur_key`=0000001C, then 0000F01C.
- Send E0 75, E0 F0 75 → events {75,1,0} and {75,1,1}; final `cur_key`=00E0F075.
- Send frame 1C with wrong parity, then 1B → `frame_err`=1 and only {1B,0,0} is queued; `clr_err` pulse → `frame_err`=0.
- Hold `evt_ready`=0 and send FIFO_DEPTH+1 makes → `fifo_count`=FIFO_DEPTH, `overflow`=1, and the first FIFO_DEPTH events pop in order.
- Stop the PS/2 clock after 5 bits for more than `TIMEOUT_CYCLES`, then send 2A → only {2A,0,0} is queued.
- With `KBD_REPEAT_FILTER_EN`, send 1C 1C 1C F0 1C 1C → queue holds {1C,0,0}, {1C,0,1}, {1C,0,0}. Drive `en`=0 mid-frame → FIFO empty, `cur_key`=0.
